// File: rtl/sha_nonce_scheduler.sv
// sha_nonce_scheduler: sequences one sha_hasher pipeline per work unit.
// Latches a unit, streams one nonce per cycle, drains, and queues hits.
// Ports: CLK/RST (sync, active-high); work_* valid/ready work intake;
//   abort cancels the unit; h_* drive the hasher, h_valid/h_time_in/
//   h_nonce_in are its results; res_* pop the hit FIFO head;
//   busy/done/overflow are status.
// Optional: define TIME_ROLL_EN to re-sweep the range with time+1,
//   up to ROLL_MAX times per unit, before draining.
module sha_nonce_scheduler #(
  parameter int PIPE_DEPTH = 64,
  parameter int RES_DEPTH  = 4,
  parameter int ROLL_MAX   = 15
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_digest_initial,
  input  logic [255:0] work_digest_in,
  input  logic [31:0]  work_merkle,
  input  logic [31:0]  work_time,
  input  logic [31:0]  work_target,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic         abort,
  output logic         h_write_en,
  output logic [255:0] h_digest_initial,
  output logic [255:0] h_digest_in,
  output logic [31:0]  h_merkle,
  output logic [31:0]  h_time,
  output logic [31:0]  h_target,
  output logic [31:0]  h_nonce,
  input  logic         h_valid,
  input  logic [31:0]  h_time_in,
  input  logic [31:0]  h_nonce_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_time,
  output logic [31:0]  res_nonce,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int CW = $clog2(PIPE_DEPTH + 1);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int RW = $clog2(ROLL_MAX + 2);
`ifdef TIME_ROLL_EN
  localparam int ROLLS = ROLL_MAX;
`else
  localparam int ROLLS = 0;
`endif

  // Counter holds drain cycles left after the current one, so the
  // final drain cycle (cnt==0) lands PIPE_DEPTH cycles after the last
  // issue, i.e. on the cycle the last result leaves the hasher.
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(PIPE_DEPTH - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          discard;
  logic [31:0]   nonce_start;
  logic [31:0]   nonce_end;
  logic [RW-1:0] roll_cnt;

  logic is_idle, is_run, is_drain;
  logic last_drain, accept, abort_go;
  logic run_step, drain_step;
  logic at_end, roll_ok;

  assign is_idle    = (state == S_IDLE);
  assign is_run     = (state == S_RUN);
  assign is_drain   = (state == S_DRAIN);
  assign last_drain = is_drain && (cnt == '0);

  // The final drain cycle already reports ready, so a new unit can be
  // taken there without an idle bubble (unless abort restarts a drain).
  assign work_ready = is_idle || (last_drain && !abort);
  assign accept     = work_valid && work_ready;
  assign abort_go   = abort && (is_run || is_drain);
  assign run_step   = is_run && !abort;
  assign drain_step = is_drain && !abort && !accept;

  assign at_end  = (h_nonce == nonce_end);
  assign roll_ok = (roll_cnt != RW'(ROLLS));

  assign h_write_en = is_run;
  assign busy       = !is_idle;
  assign done       = last_drain && !discard && !abort;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= S_IDLE;
      cnt              <= '0;
      discard          <= 1'b0;
      nonce_start      <= '0;
      nonce_end        <= '0;
      roll_cnt         <= '0;
      h_digest_initial <= '0;
      h_digest_in      <= '0;
      h_merkle         <= '0;
      h_time           <= '0;
      h_target         <= '0;
      h_nonce          <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          state            <= S_RUN;
          cnt              <= '0;
          discard          <= 1'b0;
          roll_cnt         <= '0;
          nonce_start      <= work_nonce_start;
          nonce_end        <= work_nonce_end;
          h_digest_initial <= work_digest_initial;
          h_digest_in      <= work_digest_in;
          h_merkle         <= work_merkle;
          h_time           <= work_time;
          h_target         <= work_target;
          h_nonce          <= work_nonce_start;
        end
        abort_go: begin
          state   <= S_DRAIN;
          discard <= 1'b1;
          cnt     <= DRAIN_LOAD;
        end
        run_step: begin
          if (!at_end) begin
            h_nonce <= h_nonce + 32'd1;
          end else if (roll_ok) begin
            h_nonce  <= nonce_start;
            h_time   <= h_time + 32'd1;
            roll_cnt <= roll_cnt + RW'(1);
          end else begin
            state <= S_DRAIN;
            cnt   <= DRAIN_LOAD;
          end
        end
        drain_step: begin
          if (cnt == '0) begin
            state   <= S_IDLE;
            discard <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic [63:0]   mem [RES_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full, hit, push, pop;

  assign res_valid = (count != '0);
  assign full      = (count == (AW+1)'(RES_DEPTH));
  assign pop       = res_valid && res_ready;
  assign hit       = h_valid && !discard;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign push      = hit && (!full || pop);

  assign res_time  = res_valid ? mem[rd_ptr][63:32] : 32'd0;
  assign res_nonce = res_valid ? mem[rd_ptr][31:0]  : 32'd0;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {h_time_in, h_nonce_in};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (hit && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// tb_sha_nonce_scheduler: table-driven work units plus hand-written
// abort, FIFO and reset sequences, checked against a scoreboard.
module tb_sha_nonce_scheduler;

  localparam int PD = 64;
  localparam int RD = 4;
  localparam int RM = 2;
`ifdef TIME_ROLL_EN
  localparam int ROLLS = RM;
`else
  localparam int ROLLS = 0;
`endif

  localparam logic [255:0] DIG =
    256'hF7A528B9_01234567_89ABCDEF_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_1D2CE776;
  localparam logic [255:0] DINIT =
    256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] work_digest_initial = '0;
  logic [255:0] work_digest_in = '0;
  logic [31:0]  work_merkle = '0;
  logic [31:0]  work_time = '0;
  logic [31:0]  work_target = '0;
  logic [31:0]  work_nonce_start = '0;
  logic [31:0]  work_nonce_end = '0;
  logic         abort = 1'b0;
  logic         h_write_en;
  logic [255:0] h_digest_initial;
  logic [255:0] h_digest_in;
  logic [31:0]  h_merkle;
  logic [31:0]  h_time;
  logic [31:0]  h_target;
  logic [31:0]  h_nonce;
  logic         h_valid = 1'b0;
  logic [31:0]  h_time_in = '0;
  logic [31:0]  h_nonce_in = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [31:0]  res_time;
  logic [31:0]  res_nonce;
  logic         busy;
  logic         done;
  logic         overflow;

  sha_nonce_scheduler #(
    .PIPE_DEPTH(PD),
    .RES_DEPTH(RD),
    .ROLL_MAX(RM)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .work_valid(work_valid),
    .work_ready(work_ready),
    .work_digest_initial(work_digest_initial),
    .work_digest_in(work_digest_in),
    .work_merkle(work_merkle),
    .work_time(work_time),
    .work_target(work_target),
    .work_nonce_start(work_nonce_start),
    .work_nonce_end(work_nonce_end),
    .abort(abort),
    .h_write_en(h_write_en),
    .h_digest_initial(h_digest_initial),
    .h_digest_in(h_digest_in),
    .h_merkle(h_merkle),
    .h_time(h_time),
    .h_target(h_target),
    .h_nonce(h_nonce),
    .h_valid(h_valid),
    .h_time_in(h_time_in),
    .h_nonce_in(h_nonce_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_time(res_time),
    .res_nonce(res_nonce),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [63:0] iss_q[$];
  logic [63:0] res_q[$];

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    logic [31:0] tm;
    int          n;
  } vec_t;

  vec_t vec[4];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic hit(input logic [31:0] t, input logic [31:0] n);
    @(negedge CLK);
    h_valid    = 1'b1;
    h_time_in  = t;
    h_nonce_in = n;
  endtask

  task automatic pop_all(input string nm);
    for (int c = 0; c < 2 * RD + 2; c++) begin
      if (!res_valid) break;
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_extra got=%0h want=empty", nm, res_nonce);
      end else begin
        chk(nm, {res_time, res_nonce}, res_q.pop_front());
      end
      res_ready = 1'b1;
      @(negedge CLK);
    end
    res_ready = 1'b0;
    chk({nm, "_left"}, res_q.size(), 0);
    chk({nm, "_empty_out"}, {res_time, res_nonce}, 64'd0);
    res_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int last, dcyc, ndrain, ndone;

    vec[0] = '{32'h0000_0100, 32'h0000_0103, 32'h5F5E_1000, 4};
    vec[1] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0020, 4};
    vec[2] = '{32'h0000_0007, 32'h0000_0007, 32'h0000_0010, 1};
    vec[3] = '{32'h0000_0000, 32'h0000_0009, 32'h1234_0000, 10};

    repeat (2) @(negedge CLK);
    chk("rst_ready", work_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", h_write_en, 0);
    chk("rst_done", done, 0);
    chk("rst_resv", res_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_nonce", h_nonce, 0);
    RST = 1'b0;

    for (int v = 0; v < 4; v++) begin
      @(negedge CLK);
      chk("idle_ready", work_ready, 1);
      work_valid          = 1'b1;
      work_digest_initial = DINIT;
      work_digest_in      = DIG;
      work_merkle         = 32'hCAFE_0000 + 32'(v);
      work_target         = 32'h1D00_FFFF;
      work_time           = vec[v].tm;
      work_nonce_start    = vec[v].start;
      work_nonce_end      = vec[v].stop;
      for (int r = 0; r <= ROLLS; r++)
        for (int i = 0; i < vec[v].n; i++)
          iss_q.push_back({vec[v].tm + 32'(r), vec[v].start + 32'(i)});
      @(negedge CLK);
      work_valid = 1'b0;
      chk("run_ready", work_ready, 0);
      chk("digest_in", h_digest_in, DIG);
      chk("digest_init", h_digest_initial, DINIT);
      chk("merkle", h_merkle, 32'hCAFE_0000 + 32'(v));
      last = -1;
      dcyc = -1;
      for (int c = 0; c < vec[v].n * (ROLLS + 1) + PD + 8; c++) begin
        if (h_write_en) begin
          if (iss_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_issue got=%0h want=none", h_nonce);
          end else begin
            chk("issue", {h_time, h_nonce}, iss_q.pop_front());
          end
          last = cyc;
        end
        if (done) begin
          dcyc = cyc;
          chk("done_ready", work_ready, 1);
          break;
        end
        @(negedge CLK);
      end
      chk("issue_left", iss_q.size(), 0);
      chk("drain_len", dcyc - last, PD);
      @(negedge CLK);
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
      iss_q.delete();
    end

    @(negedge CLK);
    work_valid       = 1'b1;
    work_nonce_start = 32'd0;
    work_nonce_end   = 32'd999;
    @(negedge CLK);
    work_valid = 1'b0;
    @(negedge CLK);
    chk("abort_pre_we", h_write_en, 1);
    chk("abort_pre_nonce", h_nonce, 1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_we", h_write_en, 0);
    h_valid    = 1'b1;
    h_time_in  = 32'h0BAD_0000;
    h_nonce_in = 32'h0000_0001;
    ndrain = 0;
    ndone  = 0;
    for (int c = 0; c < PD + 10; c++) begin
      if (!busy) break;
      ndrain++;
      if (done) ndone++;
      if (h_write_en) ndone += 100;
      if (work_ready) h_valid = 1'b0;
      @(negedge CLK);
    end
    h_valid = 1'b0;
    chk("abort_drain", ndrain, PD);
    chk("abort_done", ndone, 0);
    chk("abort_idle", busy, 0);
    chk("abort_nopush", res_valid, 0);

    res_ready = 1'b0;
    for (int k = 0; k < RD + 1; k++) begin
      hit(32'h5F5E_1000, 32'h1234_ABCD + 32'(k));
      if (k < RD) res_q.push_back({32'h5F5E_1000, 32'h1234_ABCD + 32'(k)});
    end
    @(negedge CLK);
    h_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_resv", res_valid, 1);
    pop_all("fifo");
    chk("ovf_sticky", overflow, 1);

    for (int k = 0; k < RD; k++) begin
      hit(32'h0000_00F0, 32'hA0 + 32'(k));
      res_q.push_back({32'h0000_00F0, 32'hA0 + 32'(k)});
    end
    hit(32'h0000_00F1, 32'hAF);
    res_ready = 1'b1;
    chk("simul_head", {res_time, res_nonce}, res_q.pop_front());
    res_q.push_back({32'h0000_00F1, 32'hAF});
    @(negedge CLK);
    h_valid   = 1'b0;
    res_ready = 1'b0;
    pop_all("simul");

    hit(32'h1, 32'h11);
    hit(32'h2, 32'h22);
    @(negedge CLK);
    h_valid          = 1'b0;
    work_valid       = 1'b1;
    work_nonce_start = 32'd0;
    work_nonce_end   = 32'd999;
    @(negedge CLK);
    work_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_resv", res_valid, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resv", res_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_ready", work_ready, 1);
    chk("mid_rst_we", h_write_en, 0);
    RST = 1'b0;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_nonce_scheduler.md
Name: sha_nonce_scheduler

Overview:
Work dispatcher that sequences one sha_hasher pipeline.
- Accepts a work unit: initial digest, midstate, merkle tail, time, target and nonce range.
- Streams one nonce per cycle into the hasher, then drains the pipeline.
- Captures hasher hits into a small result FIFO for the host/UART side.

Parameters:
PIPE_DEPTH, 64, cycles from a nonce issued on h_nonce (h_write_en=1) to its h_valid/h_nonce_in result
RES_DEPTH, 4, result FIFO entries (power of 2, >=2)
ROLL_MAX, 15, max time increments per work unit (used only with TIME_ROLL_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
work_valid  in  1  work unit offered
work_ready  out  1  scheduler can accept work
work_digest_initial  in  256  digest added after final round
work_digest_in  in  256  midstate
work_merkle  in  32  merkle tail word
work_time  in  32  header time
work_target  in  32  compact target
work_nonce_start  in  32  first nonce
work_nonce_end  in  32  last nonce, inclusive
abort  in  1  cancel current work unit
h_write_en  out  1  hasher input strobe
h_digest_initial  out  256  to hasher digest_intial
h_digest_in  out  256  to hasher digest_in
h_merkle  out  32  to hasher merkle_in
h_time  out  32  to hasher time_in
h_target  out  32  to hasher target_in
h_nonce  out  32  to hasher nonce_in
h_valid  in  1  hasher valid_out
h_time_in  in  32  hasher time_out
h_nonce_in  in  32  hasher nonce_out
res_valid  out  1  result FIFO not empty
res_ready  in  1  consumer pops head
res_time  out  32  head entry time
res_nonce  out  32  head entry nonce
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, work unit completed normally
overflow  out  1  sticky: hit dropped because FIFO full

Behaviour:
- Reset values: all outputs 0 except work_ready=1. State IDLE, FIFO empty, overflow cleared.
- States: IDLE, RUN, DRAIN.
- IDLE
  - work_ready=1, h_write_en=0.
  - work_valid=1 latches all work_* fields into registers driving h_* and sets h_nonce=work_nonce_start.
  - Next state RUN; work_ready=0 from the following cycle.
- RUN
  - h_write_en=1 every cycle; h_nonce increments by 1 per cycle, mod 2^32.
  - Range end: on the cycle h_nonce==end is presented, next state is DRAIN and the drain counter loads PIPE_DEPTH.
  - Wrap: end<start sweeps through 0xFFFFFFFF to 0 (2^32-start+end+1 nonces). start==end issues exactly one nonce.
- DRAIN
  - h_write_en=0, h_* held. Counter decrements once per cycle.
  - At 0: done=1 for one cycle, return to IDLE; work_ready=1 on that same cycle.
- abort
  - In RUN or DRAIN: next state DRAIN with discard flag set; counter reloads PIPE_DEPTH.
  - No done pulse. h_valid is ignored while discard=1. The flag clears on return to IDLE.
  - abort in IDLE is ignored. abort with work_valid in IDLE: work is accepted.
- Result capture
  - When h_valid=1, discard=0 and the FIFO is not full, push {h_time_in, h_nonce_in}. This applies in any state, including IDLE.
  - FIFO full with h_valid=1: drop the hit and set overflow=1 until RST.
  - Simultaneous push and pop on a full FIFO: the pop occurs and the push is accepted (no drop).
  - res_* show the head entry; they are 0 when empty. Pop when res_valid&&res_ready.
- work_valid outside IDLE is ignored; no queueing.

Optional Feature:
Macro TIME_ROLL_EN.
- Defined: when RUN reaches end and fewer than ROLL_MAX rolls have been done in this unit, skip DRAIN.
  - h_time increments by 1 and h_nonce reloads start on the next cycle, with h_write_en staying 1 (no bubble).
  - The roll count resets on work accept.
- Undefined: ROLL_MAX is unused; behaviour is exactly as above.

Test Plan:
- Load start=0x100, end=0x103, PIPE_DEPTH=64, digest_in=F7A528B9...E776 -> h_write_en high 4 cycles with h_nonce 0x100..0x103; done pulses 64 cycles after the last issue; work_ready=1 on the done cycle.
- start=0xFFFFFFFE, end=0x1 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 on consecutive cycles, then DRAIN.
- Drive h_valid with nonce 0x1234ABCD, time 0x5F5E1000 while res_ready=0, repeated 5 times -> 4 entries queued, overflow=1; popping returns the first 4 in order.
- abort 2 cycles into RUN of a 1000-nonce range -> h_write_en=0 next cycle, h_valid during the 64-cycle drain is not pushed, no done pulse, IDLE after the drain.
- RST=1 mid-RUN with FIFO holding 2 entries -> next cycle: IDLE, res_valid=0, overflow=0, work_ready=1, h_write_en=0.
- TIME_ROLL_EN, ROLL_MAX=2, start=end=0x7, time=0x10 -> nonce 7 issued 3 cycles consecutively with times 0x10, 0x11, 0x12, then a single done.
